draw_text_box: RTL

//  Overlays a rectangular text field on the VGA pixel stream, one stage after the background/object draw stages.
//  Per pixel it computes char_xy (linear char index) for a char_rom_* text ROM, then builds the 11-bit font ROM address.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/delay.sv | 35 +++
 rtl/draw_text_box.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
//==============================================================================
// Package  : vga_pkg
// Shared VGA stream widths, glyph geometry and the packed timing bus type.
// Revision : 1.0
//==============================================================================
package vga_pkg;

    localparam int HCOUNT_W  = 11;
    localparam int VCOUNT_W  = 11;
    localparam int RGB_W     = 12;
    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int CHAR_XY_W = 12;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
        logic                hsync;
        logic                vsync;
        logic                hblnk;
        logic                vblnk;
    } vga_timing_t;

    localparam int TIMING_W = $bits(vga_timing_t);

endpackage
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
//==============================================================================
// Module   : delay
// Fixed-latency shift register with synchronous active-high reset.
// Revision : 1.0
//==============================================================================
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (CLK_DEL < 1) begin : g_del_check
        $error("delay: CLK_DEL must be at least 1");
    end

    logic [WIDTH-1:0] r_stage [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign dout = r_stage[CLK_DEL-1];

endmodule
`default_nettype wire

// File: rtl/draw_text_box.sv
`default_nettype none
//==============================================================================
// Module   : draw_text_box
// Overlays a text field on the VGA stream via external text and font ROMs,
// 4-clock latency. Optional macro TEXT_BLINK_EN adds frame-rate blinking.
// Revision : 1.0
//==============================================================================
module draw_text_box
    import vga_pkg::*;
#(
    parameter int               X_POS      = 100,
    parameter int               Y_POS      = 200,
    parameter int               COLS       = 32,
    parameter int               ROWS       = 4,
    parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hFFF,
    parameter int               BLINK_LOG  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HCOUNT_W-1:0]  hcount_in,
    input  logic [VCOUNT_W-1:0]  vcount_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 hblnk_in,
    input  logic                 vblnk_in,
    input  logic [RGB_W-1:0]     rgb_in,
    output logic [CHAR_XY_W-1:0] char_xy,
    input  logic [6:0]           char_code,
    output logic [10:0]          font_addr,
    input  logic [CHAR_W-1:0]    char_pixels,
    output logic [HCOUNT_W-1:0]  hcount_out,
    output logic [VCOUNT_W-1:0]  vcount_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 hblnk_out,
    output logic                 vblnk_out,
    output logic [RGB_W-1:0]     rgb_out
);

    localparam int c_XSH = $clog2(CHAR_W);
    localparam int c_YSH = $clog2(CHAR_H);
    localparam logic [HCOUNT_W-1:0] c_X_LO = HCOUNT_W'(X_POS);
    localparam logic [HCOUNT_W-1:0] c_X_HI = HCOUNT_W'(X_POS + COLS*CHAR_W - 1);
    localparam logic [VCOUNT_W-1:0] c_Y_LO = VCOUNT_W'(Y_POS);
    localparam logic [VCOUNT_W-1:0] c_Y_HI = VCOUNT_W'(Y_POS + ROWS*CHAR_H - 1);

    if ((ROWS*COLS - 1) > ((1 << CHAR_XY_W) - 1) || BLINK_LOG < 0) begin : g_param_check
        $error("draw_text_box: last cell index exceeds char_xy range or BLINK_LOG negative");
    end

    // ---- Stage 1: field test and character addressing
    logic                  w_in_box;
    logic [HCOUNT_W-1:0]   w_dx;
    logic [VCOUNT_W-1:0]   w_dy;
    logic [CHAR_XY_W-1:0]  w_lin;

    assign w_in_box = (hcount_in >= c_X_LO) && (hcount_in <= c_X_HI) &&
                      (vcount_in >= c_Y_LO) && (vcount_in <= c_Y_HI);
    assign w_dx  = w_in_box ? (hcount_in - c_X_LO) : '0;
    assign w_dy  = w_in_box ? (vcount_in - c_Y_LO) : '0;
    assign w_lin = CHAR_XY_W'(32'(w_dy >> c_YSH) * 32'(COLS) + 32'(w_dx >> c_XSH));

    logic [CHAR_XY_W-1:0] r_char_xy;
    logic [c_YSH-1:0]     r_char_line, r_char_line_d;
    logic [c_XSH-1:0]     r_char_x, r_char_x_d, r_char_x_d2;
    logic                 r_in_box, r_in_box_d, r_in_box_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_char_xy     <= '0;
            r_char_line   <= '0;
            r_char_x      <= '0;
            r_in_box      <= 1'b0;
            r_char_line_d <= '0;
            r_char_x_d    <= '0;
            r_in_box_d    <= 1'b0;
            r_char_x_d2   <= '0;
            r_in_box_d2   <= 1'b0;
        end else begin
            r_char_xy     <= w_lin;
            r_char_line   <= w_dy[c_YSH-1:0];
            r_char_x      <= w_dx[c_XSH-1:0];
            r_in_box      <= w_in_box;
            r_char_line_d <= r_char_line;
            r_char_x_d    <= r_char_x;
            r_in_box_d    <= r_in_box;
            r_char_x_d2   <= r_char_x_d;
            r_in_box_d2   <= r_in_box_d;
        end
    end

    assign char_xy   = r_char_xy;
    // char_code belongs to the pixel that produced r_char_xy one clock ago
    assign font_addr = {char_code, r_char_line_d};

    // ---- Blink control
    logic w_visible;
`ifdef TEXT_BLINK_EN
    logic [BLINK_LOG:0] r_frame_cnt;
    logic               r_vsync_prev;
    logic               r_visible;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt  <= '0;
            r_vsync_prev <= 1'b0;
            r_visible    <= 1'b1;
        end else begin
            r_vsync_prev <= vsync_in;
            if (vsync_in && !r_vsync_prev) r_frame_cnt <= r_frame_cnt + 1'b1;
            // only refreshed in vertical blank so a frame is never half-drawn
            if (vblnk_in) r_visible <= ~r_frame_cnt[BLINK_LOG];
        end
    end
    assign w_visible = r_visible;
`else
    assign w_visible = 1'b1;
`endif

    // ---- Delay lines and stage 4 colour mux
    vga_timing_t      w_tim_in, w_tim_d4;
    logic [RGB_W-1:0] w_rgb_d3;
    logic [1:0]       w_blnk_d3;
    logic             w_bit;
    logic [RGB_W-1:0] r_rgb;

    assign w_tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    delay #(.WIDTH(TIMING_W), .CLK_DEL(4)) u_tim_dly (
        .clk(clk), .rst(rst), .din(w_tim_in), .dout(w_tim_d4));
    delay #(.WIDTH(RGB_W), .CLK_DEL(3)) u_rgb_dly (
        .clk(clk), .rst(rst), .din(rgb_in), .dout(w_rgb_d3));
    delay #(.WIDTH(2), .CLK_DEL(3)) u_blnk_dly (
        .clk(clk), .rst(rst), .din({hblnk_in, vblnk_in}), .dout(w_blnk_d3));

    assign w_bit = char_pixels[c_XSH'(CHAR_W-1) - r_char_x_d2];

    always_ff @(posedge clk) begin
        if (rst)                                   r_rgb <= '0;
        else if (|w_blnk_d3)                       r_rgb <= '0;
        else if (r_in_box_d2 && w_bit && w_visible) r_rgb <= TEXT_COLOR;
        else                                       r_rgb <= w_rgb_d3;
    end

    assign rgb_out    = r_rgb;
    assign hcount_out = w_tim_d4.hcount;
    assign vcount_out = w_tim_d4.vcount;
    assign hsync_out  = w_tim_d4.hsync;
    assign vsync_out  = w_tim_d4.vsync;
    assign hblnk_out  = w_tim_d4.hblnk;
    assign vblnk_out  = w_tim_d4.vblnk;

endmodule
`default_nettype wire
